// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner signal bundle: row sense lines in, column drive and key events out.
// master = scanner side, slave = consumer/keypad side.
interface keypad_matrix_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_out;
    logic [KW-1:0]   key_code;
    logic            key_valid;
    logic            key_release;
    logic            key_held;
    logic            ghost;

    modport master (
        input  row_in,
        output col_out, key_code, key_valid, key_release, key_held, ghost
    );

    modport slave (
        output row_in,
        input  col_out, key_code, key_valid, key_release, key_held, ghost
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: one-hot column drive, debounced press/release, ghost
// rejection and optional typematic repeat. All outputs are registered.
module keypad_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_TICKS   = 20,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_RATE    = 8
) (
    input logic                     clk,
    input logic                     rst,
    keypad_matrix_scanner_if.master kp
);
    localparam int KW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW   = $clog2(SETTLE_TICKS + 1);
    localparam int DW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int PW   = $clog2(RMAX + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);
    localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_SCANS);
    localparam logic [PW-1:0] REP_DLY     = PW'(REPEAT_DELAY);
    localparam logic [PW-1:0] REP_RATE    = PW'(REPEAT_RATE);
    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD_SETTLE,
        ST_HOLD_SAMPLE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   set_cnt_q, set_cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [COLS-1:0] col_out_q, col_out_d;
    logic [KW-1:0]   cand_q, cand_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [PW-1:0]   rep_q, rep_d;
    logic            armed_q, armed_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_release_q, key_release_d;
    logic            key_held_q, key_held_d;
    logic            ghost_q, ghost_d;

    int              n_ones;
    logic [RW-1:0]   hit_row;
    logic [KW-1:0]   code;
    logic [CW-1:0]   col_next;
    logic [DW-1:0]   cnt_n;
    logic [PW-1:0]   rep_n;

    // Row decode; hit_row is only meaningful when exactly one row is set.
    always_comb begin
        n_ones  = 0;
        hit_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (kp.row_in[r]) begin
                n_ones  = n_ones + 1;
                hit_row = RW'(r);
            end
        end
        code     = KW'(int'(col_q) * ROWS + int'(hit_row));
        col_next = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    end

    always_comb begin
        state_d       = state_q;
        set_cnt_d     = set_cnt_q;
        col_d         = col_q;
        col_out_d     = col_out_q;
        cand_d        = cand_q;
        row_d         = row_q;
        deb_d         = deb_q;
        rep_d         = rep_q;
        armed_d       = armed_q;
        key_code_d    = key_code_q;
        key_held_d    = key_held_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        ghost_d       = 1'b0;
        cnt_n         = '0;
        rep_n         = '0;

        case (state_q)
            ST_SETTLE, ST_HOLD_SETTLE: begin
                if (set_cnt_q == SETTLE_LAST) begin
                    set_cnt_d = '0;
                    state_d   = (state_q == ST_SETTLE) ? ST_SAMPLE : ST_HOLD_SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + SW'(1);
                end
            end

            ST_SAMPLE: begin
                state_d = ST_SETTLE;
                if (n_ones != 1) begin
                    ghost_d   = (n_ones > 1);
                    deb_d     = '0;
                    col_d     = col_next;
                    col_out_d = COLS'(1) << col_next;
                end else begin
                    // deb_q == 0 means no live candidate
                    if (deb_q != '0 && cand_q == code)
                        cnt_n = (deb_q == DEB_MAX) ? deb_q : deb_q + DW'(1);
                    else
                        cnt_n = DW'(1);
                    cand_d = code;
                    deb_d  = cnt_n;
                    if (cnt_n >= DEB_MAX) begin
                        key_code_d  = code;
                        row_d       = hit_row;
                        key_held_d  = 1'b1;
                        key_valid_d = 1'b1;
                        deb_d       = '0;
                        rep_d       = '0;
                        armed_d     = 1'b0;
                        state_d     = ST_HOLD_SETTLE;
                    end
                end
            end

            ST_HOLD_SAMPLE: begin
                state_d = ST_HOLD_SETTLE;
                if (kp.row_in[row_q]) begin
                    deb_d = '0;
                    if (REPEAT_DELAY != 0) begin
                        rep_n = (rep_q == '1) ? rep_q : rep_q + PW'(1);
                        rep_d = rep_n;
                        if (!armed_q && rep_n == REP_DLY) begin
                            key_valid_d = 1'b1;
                            armed_d     = 1'b1;
                            rep_d       = '0;
                        end else if (armed_q && rep_n == REP_RATE) begin
                            key_valid_d = 1'b1;
                            rep_d       = '0;
                        end
                    end
                end else begin
                    cnt_n = (deb_q == DEB_MAX) ? deb_q : deb_q + DW'(1);
                    deb_d = cnt_n;
                    if (cnt_n >= DEB_MAX) begin
                        key_release_d = 1'b1;
                        key_held_d    = 1'b0;
                        deb_d         = '0;
                        rep_d         = '0;
                        armed_d       = 1'b0;
                        col_d         = col_next;
                        col_out_d     = COLS'(1) << col_next;
                        state_d       = ST_SETTLE;
                    end
                end
            end

            default: begin
                state_d   = ST_SETTLE;
                set_cnt_d = '0;
                col_d     = '0;
                col_out_d = COLS'(1);
                deb_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SETTLE;
            set_cnt_q     <= '0;
            col_q         <= '0;
            col_out_q     <= COLS'(1);
            cand_q        <= '0;
            row_q         <= '0;
            deb_q         <= '0;
            rep_q         <= '0;
            armed_q       <= 1'b0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
            ghost_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            set_cnt_q     <= set_cnt_d;
            col_q         <= col_d;
            col_out_q     <= col_out_d;
            cand_q        <= cand_d;
            row_q         <= row_d;
            deb_q         <= deb_d;
            rep_q         <= rep_d;
            armed_q       <= armed_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_held_q    <= key_held_d;
            ghost_q       <= ghost_d;
        end
    end

    assign kp.col_out     = col_out_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_release = key_release_q;
    assign kp.key_held    = key_held_q;
    assign kp.ghost       = ghost_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench: a behavioural keypad drives the rows from col_out; one default
// scanner plus one with auto-repeat (delay 4, rate 2).
module tb_keypad_matrix_scanner;
  localparam int P = 21;  // SETTLE_TICKS + 1 cycles per sample

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_matrix_scanner_if #(.ROWS(4), .COLS(4)) kp ();
  keypad_matrix_scanner_if #(.ROWS(4), .COLS(4)) kr ();

  keypad_matrix_scanner dut (.clk(clk), .rst(rst), .kp(kp));
  keypad_matrix_scanner #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_r (.clk(clk), .rst(rst), .kp(kr));

  // keys[c*4+r] pressed shorts column c to row r
  logic [15:0] keys, keys_r;
  always_comb begin
    kp.row_in = '0;
    kr.row_in = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && kp.col_out[c]) kp.row_in[r] = 1'b1;
        if (keys_r[c*4+r] && kr.col_out[c]) kr.row_in[r] = 1'b1;
      end
  end

  int n_valid = 0, n_rel = 0, n_ghost = 0, n_rvalid = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (kp.key_valid) n_valid++;
    if (kp.key_release) n_rel++;
    if (kp.ghost) n_ghost++;
    if (kr.key_valid) n_rvalid++;
    if ((kp.key_valid && kp.key_release) || (kp.ghost && (kp.key_valid || kp.key_release)) ||
        (kr.key_valid && kr.key_release))
      n_overlap++;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic samples(input int n);
    repeat (n * P) @(negedge clk);
  endtask

  int base_v, base_g, base_r, base_rv;
  bit exp_v;

  initial begin
    keys = '0; keys_r = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", int'(kp.col_out), 1);
    chk("rst_code", int'(kp.key_code), 0);
    chk("rst_flags", int'({kp.key_valid, kp.key_release, kp.key_held, kp.ghost}), 0);

    // key (col 2, row 1) = code 9; seen on samples 3,4,5
    keys = 16'(1) << 9;
    rst = 1'b0;
    samples(4);
    chk("t1_early", int'(kp.key_valid), 0);
    base_v = n_valid;
    samples(1);
    chk("t1_valid", int'(kp.key_valid), 1);
    chk("t1_code", int'(kp.key_code), 9);
    chk("t1_held", int'(kp.key_held), 1);
    @(negedge clk);
    chk("t1_strobe_1cyc", int'(kp.key_valid), 0);
    repeat (P - 1) @(negedge clk);
    samples(2);
    keys = '0;
    samples(2);
    chk("t1_held_pre", int'(kp.key_held), 1);
    chk("t1_rel_pre", int'(kp.key_release), 0);
    samples(1);
    chk("t1_release", int'(kp.key_release), 1);
    chk("t1_held_off", int'(kp.key_held), 0);
    chk("t1_col_adv", int'(kp.col_out), 4'b1000);
    chk("t1_no_repeat", n_valid - base_v, 1);

    // short press on column 3: two samples only
    keys = 16'(1) << 12;
    base_v = n_valid;
    samples(2);
    keys = '0;
    chk("t2_col_stay", int'(kp.col_out), 4'b1000);
    samples(1);
    chk("t2_col_wrap", int'(kp.col_out), 4'b0001);
    chk("t2_no_valid", n_valid - base_v, 0);

    // ghost: rows 1 and 2 on column 1
    keys = (16'(1) << 5) | (16'(1) << 6);
    base_g = n_ghost;
    samples(2);
    chk("t3_ghost", int'(kp.ghost), 1);
    chk("t3_col_adv", int'(kp.col_out), 4'b0100);
    chk("t3_no_valid", int'(kp.key_valid), 0);
    keys = 16'(1) << 11;
    @(negedge clk);
    chk("t3_ghost_1cyc", int'(kp.ghost), 0);
    repeat (P - 1) @(negedge clk);
    chk("t3_ghost_cnt", n_ghost - base_g, 1);

    // code 11 accepted, then release pattern 0,1,0,0,0
    base_v = n_valid;
    samples(2);
    chk("t4_valid", int'(kp.key_valid), 1);
    chk("t4_code", int'(kp.key_code), 11);
    keys = '0;
    samples(1);
    keys = 16'(1) << 11;
    samples(1);
    keys = '0;
    samples(2);
    chk("t4_held_glitch", int'(kp.key_held), 1);
    chk("t4_no_rel_yet", int'(kp.key_release), 0);
    samples(1);
    chk("t4_release", int'(kp.key_release), 1);
    chk("t4_held_off", int'(kp.key_held), 0);
    chk("t4_col_adv", int'(kp.col_out), 4'b1000);
    chk("t4_single_valid", n_valid - base_v, 1);

    // reset while holding code 14
    keys = 16'(1) << 14;
    samples(3);
    chk("t5_valid", int'(kp.key_valid), 1);
    chk("t5_code", int'(kp.key_code), 14);
    repeat (5) @(negedge clk);
    chk("t5_held", int'(kp.key_held), 1);
    base_r = n_rel;
    rst = 1'b1;
    #1;
    chk("t5_rst_col", int'(kp.col_out), 1);
    chk("t5_rst_code", int'(kp.key_code), 0);
    chk("t5_rst_flags", int'({kp.key_valid, kp.key_release, kp.key_held, kp.ghost}), 0);
    keys = '0;
    repeat (3) @(negedge clk);

    // repeat scanner: code 5 (col 1, row 1) accepted at sample 4, held 12 more
    keys_r = 16'(1) << 5;
    base_rv = n_rvalid;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      samples(1);
      exp_v = (k == 4) || (k >= 8 && k % 2 == 0);
      chk($sformatf("t6_valid_s%0d", k), int'(kr.key_valid), int'(exp_v));
      if (k >= 4) begin
        chk($sformatf("t6_code_s%0d", k), int'(kr.key_code), 5);
        chk($sformatf("t6_held_s%0d", k), int'(kr.key_held), 1);
      end
      if (k == 1) chk("t5_scan_resume", int'(kp.col_out), 4'b0010);
    end
    keys_r = '0;
    samples(3);
    chk("t6_release", int'(kr.key_release), 1);
    chk("t6_held_off", int'(kr.key_held), 0);
    chk("t6_valid_cnt", n_rvalid - base_rv, 6);
    chk("t5_no_release", n_rel - base_r, 0);
    chk("strobe_overlap", n_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
